// File: rtl/alu_dec_mdu.sv
// ALU auxiliary decoder plus an iterative multiply/divide unit that owns HI/LO.
// Define MDU_SIGNED_EN to add signed MULT/DIV on top of the default unsigned MULTU/DIVU.
module alu_dec_mdu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [3:0]        alu_ctrl,
  output logic              mf_sel,
  output logic [DATA_W-1:0] mf_data,
  output logic              stall,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic              div_zero
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic                dz_q, dz_d;
  logic                neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

  always_comb begin
    alu_ctrl = 4'b1111;
    case (alu_op)
      2'b00: alu_ctrl = 4'b0010;
      2'b01: alu_ctrl = 4'b0110;
      2'b11: alu_ctrl = 4'b0001;
      default: begin
        case (funct)
          6'b100100: alu_ctrl = 4'b0000;
          6'b100101: alu_ctrl = 4'b0001;
          6'b100000: alu_ctrl = 4'b0010;
          6'b100010: alu_ctrl = 4'b0110;
          6'b101010: alu_ctrl = 4'b0111;
          6'b100110: alu_ctrl = 4'b0011;
          6'b100111: alu_ctrl = 4'b1100;
          6'b000000: alu_ctrl = 4'b1000;
          6'b000010: alu_ctrl = 4'b1001;
          default:   alu_ctrl = 4'b1111;
        endcase
      end
    endcase
  end

  logic is_rtype, is_mf, is_mul, is_div, is_signed;
  assign is_rtype = (alu_op == 2'b10);
  assign is_mf    = (funct == F_MFHI) || (funct == F_MFLO);
`ifdef MDU_SIGNED_EN
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
`else
  assign is_signed = 1'b0;
`endif
  assign is_mul = (funct == F_MULTU) || (is_signed && funct == F_MULT);
  assign is_div = (funct == F_DIVU)  || (is_signed && funct == F_DIV);

  logic mdu_op, hilo_use, issue;
  assign mdu_op   = op_valid && is_rtype && (is_mul || is_div);
  assign hilo_use = op_valid && is_rtype && (is_mul || is_div || is_mf);
  assign mdu_busy = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign mdu_done = (state_q == ST_DONE);
  assign stall    = mdu_busy && hilo_use;
  assign issue    = mdu_op && !stall;
  assign mf_sel   = is_rtype && is_mf;
  assign mf_data  = (funct == F_MFHI) ? hi_q : lo_q;
  assign div_zero = dz_q;

  // Signed ops iterate on magnitudes; signs are reapplied when the result is written.
  logic              neg_a, neg_b;
  logic [DATA_W-1:0] mag_a, mag_b;
  assign neg_a = is_signed && rs_data[DATA_W-1];
  assign neg_b = is_signed && rt_data[DATA_W-1];
  assign mag_a = neg_a ? (~rs_data + 1'b1) : rs_data;
  assign mag_b = neg_b ? (~rt_data + 1'b1) : rt_data;

  // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, then shift right.
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next, mul_res;
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};
  assign mul_res  = neg_res_q ? (~mul_next + 1'b1) : mul_next;

  // Divide: acc = {remainder, dividend/quotient}; shift left one bit and trial-subtract.
  logic [DATA_W:0]     div_shift, div_trial;
  logic [2*DATA_W-1:0] div_next;
  logic [DATA_W-1:0]   quo, rem, dz_hi;
  assign div_shift = acc_q[2*DATA_W-1:DATA_W-1];
  assign div_trial = div_shift - {1'b0, opb_q};
  assign div_next  = div_trial[DATA_W] ? {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                       : {div_trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
  assign quo   = neg_res_q ? (~div_next[DATA_W-1:0] + 1'b1) : div_next[DATA_W-1:0];
  assign rem   = neg_rem_q ? (~div_next[2*DATA_W-1:DATA_W] + 1'b1) : div_next[2*DATA_W-1:DATA_W];
  assign dz_hi = neg_rem_q ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    case (state_q)
      ST_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          {hi_d, lo_d} = mul_res;
          state_d      = ST_DONE;
        end
      end
      ST_DIV: begin
        if (opb_q == '0) begin
          lo_d    = '1;
          hi_d    = dz_hi;
          dz_d    = 1'b1;
          state_d = ST_DONE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            lo_d    = quo;
            hi_d    = rem;
            dz_d    = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (issue) begin
      state_d   = is_div ? ST_DIV : ST_MUL;
      cnt_d     = '0;
      opb_d     = is_div ? mag_b : mag_a;
      acc_d     = is_div ? {{DATA_W{1'b0}}, mag_a} : {{DATA_W{1'b0}}, mag_b};
      neg_res_d = neg_a ^ neg_b;
      neg_rem_d = neg_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule
